// File: rtl/shot_seq_pkg.sv
// Shared definitions for the shot sequencer: FSM state encoding and default
// bus widths used as parameter defaults by shot_sequencer.
package shot_seq_pkg;

    localparam int unsigned NSHOT_W_DEF = 16;
    localparam int unsigned DELAY_W_DEF = 16;
    localparam int unsigned DECIM_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF  = 12;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TRIG  = 3'd1,
        ST_DELAY = 3'd2,
        ST_ACQ   = 3'd3,
        ST_ARM   = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

endpackage

// File: rtl/decim_strobe.sv
// Decimation phase counter. Phase 0 marks a write slot, phase == decim_i marks
// the last cycle of a decimation period. clr_i holds the phase at 0 so the
// first cycle after clr_i drops is always a write slot.
//   clk, reset    : clock, async active-high reset
//   clr_i         : restart the decimation period
//   decim_i       : period minus one
//   strobe_c_o    : write slot this cycle (combinational)
//   last_c_o      : last cycle of the current period (combinational)
module decim_strobe #(
    parameter int unsigned DECIM_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clr_i,
    input  logic [DECIM_W-1:0] decim_i,
    output logic               strobe_c_o,
    output logic               last_c_o
);

    logic [DECIM_W-1:0] phase_q, phase_d;

    // Wrap at decim_i, restart on clear
    always_comb begin
        phase_d = phase_q + DECIM_W'(1);
        if (clr_i || (phase_q == decim_i)) begin
            phase_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign strobe_c_o = (phase_q == '0);
    assign last_c_o   = (phase_q == decim_i);

endmodule

// File: rtl/shot_sequencer.sv
// Shot-level acquisition controller. A start strobe latches the shot
// configuration and runs nshot shots of: trigger, post-trigger delay,
// decimated buffer writes, then wait for downstream re-arm.
//   clk, reset                       : clock, async active-high reset
//   stb_start, stb_abort             : one-cycle control strobes
//   nshot, delayaftertrig, decimator,
//   acqlen, resetacc                 : configuration, latched on start
//   rearm                            : downstream ready for next shot
//   busy, trig, acq_we, acq_addr     : sequence status and buffer write port
//   acc_clr, acqbuf_rst              : one-cycle clears issued at start
//   shotcnt, lastshotdone            : completed shots, sticky done flag
// All outputs are registered and follow the FSM state by one cycle.
module shot_sequencer
    import shot_seq_pkg::*;
#(
    parameter int unsigned NSHOT_W = NSHOT_W_DEF,
    parameter int unsigned DELAY_W = DELAY_W_DEF,
    parameter int unsigned DECIM_W = DECIM_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stb_start,
    input  logic               stb_abort,
    input  logic [NSHOT_W-1:0] nshot,
    input  logic [DELAY_W-1:0] delayaftertrig,
    input  logic [DECIM_W-1:0] decimator,
    input  logic [ADDR_W-1:0]  acqlen,
    input  logic               resetacc,
    input  logic               rearm,
    output logic               busy,
    output logic               trig,
    output logic               acq_we,
    output logic [ADDR_W-1:0]  acq_addr,
    output logic               acc_clr,
    output logic               acqbuf_rst,
    output logic [NSHOT_W-1:0] shotcnt,
    output logic               lastshotdone
);

    state_e             state_q, state_d;
    logic [NSHOT_W-1:0] nshot_q;
    logic [DELAY_W-1:0] delay_q, dly_cnt_q;
    logic [DECIM_W-1:0] decim_q;
    logic [ADDR_W-1:0]  acqlen_q, wr_cnt_q, wr_cnt_d;

    logic               busy_q, busy_d, trig_q, trig_d, acq_we_q, acq_we_d;
    logic               acc_clr_q, acc_clr_d, acqbuf_rst_q, acqbuf_rst_d;
    logic               lastshotdone_q, lastshotdone_d;
    logic [ADDR_W-1:0]  acq_addr_q, acq_addr_d;
    logic [NSHOT_W-1:0] shotcnt_q, shotcnt_d;

    logic start_go, abort_go, strobe_c, last_c, acq_done_c;

    // Abort beats start in IDLE; start is ignored outside IDLE
    assign start_go = (state_q == ST_IDLE) && stb_start && !stb_abort;
    assign abort_go = (state_q != ST_IDLE) && stb_abort;

    decim_strobe #(
        .DECIM_W (DECIM_W)
    ) u_decim (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (state_q != ST_ACQ),
        .decim_i    (decim_q),
        .strobe_c_o (strobe_c),
        .last_c_o   (last_c)
    );

    // Writes issued in this shot including the current cycle
    always_comb begin
        wr_cnt_d = '0;
        if (state_q == ST_ACQ) begin
            wr_cnt_d = wr_cnt_q + ADDR_W'(strobe_c);
        end
    end

    // ACQ ends on the last decimation cycle after the final write
    assign acq_done_c = last_c && (wr_cnt_d == acqlen_q);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (abort_go) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_go) begin
                        state_d = (nshot == '0) ? ST_DONE : ST_TRIG;
                    end
                end
                ST_TRIG: begin
                    if (delay_q != '0) begin
                        state_d = ST_DELAY;
                    end else begin
                        state_d = (acqlen_q == '0) ? ST_ARM : ST_ACQ;
                    end
                end
                ST_DELAY: begin
                    if (dly_cnt_q == delay_q - DELAY_W'(1)) begin
                        state_d = (acqlen_q == '0) ? ST_ARM : ST_ACQ;
                    end
                end
                ST_ACQ: begin
                    if (acq_done_c) begin
                        state_d = ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (shotcnt_q == nshot_q) begin
                        state_d = ST_DONE;
                    end else if (rearm) begin
                        state_d = ST_TRIG;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output logic (next values of the output registers)
    always_comb begin
        busy_d         = (state_d != ST_IDLE);
        trig_d         = (state_q == ST_TRIG) && !abort_go;
        acq_we_d       = (state_q == ST_ACQ) && strobe_c && !abort_go;
        acq_addr_d     = acq_addr_q;
        acc_clr_d      = start_go && resetacc;
        acqbuf_rst_d   = start_go;
        shotcnt_d      = shotcnt_q;
        lastshotdone_d = lastshotdone_q;

        // Address shows the current write index and advances after it
        if (state_q == ST_TRIG) begin
            acq_addr_d = '0;
        end else if (acq_we_q) begin
            acq_addr_d = acq_addr_q + ADDR_W'(1);
        end

        // A shot completes whenever the FSM enters ARM
        if (start_go) begin
            shotcnt_d      = '0;
            lastshotdone_d = 1'b0;
        end else if ((state_d == ST_ARM) && (state_q != ST_ARM)) begin
            shotcnt_d = shotcnt_q + NSHOT_W'(1);
        end

        if ((state_q == ST_DONE) && !abort_go) begin
            lastshotdone_d = 1'b1;
        end
    end

    // Configuration latch and per-shot counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nshot_q   <= '0;
            delay_q   <= '0;
            decim_q   <= '0;
            acqlen_q  <= '0;
            dly_cnt_q <= '0;
            wr_cnt_q  <= '0;
        end else begin
            if (start_go) begin
                nshot_q  <= nshot;
                delay_q  <= delayaftertrig;
                decim_q  <= decimator;
                acqlen_q <= acqlen;
            end
            dly_cnt_q <= (state_q == ST_DELAY) ? dly_cnt_q + DELAY_W'(1) : '0;
            wr_cnt_q  <= wr_cnt_d;
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q         <= 1'b0;
            trig_q         <= 1'b0;
            acq_we_q       <= 1'b0;
            acq_addr_q     <= '0;
            acc_clr_q      <= 1'b0;
            acqbuf_rst_q   <= 1'b0;
            shotcnt_q      <= '0;
            lastshotdone_q <= 1'b0;
        end else begin
            busy_q         <= busy_d;
            trig_q         <= trig_d;
            acq_we_q       <= acq_we_d;
            acq_addr_q     <= acq_addr_d;
            acc_clr_q      <= acc_clr_d;
            acqbuf_rst_q   <= acqbuf_rst_d;
            shotcnt_q      <= shotcnt_d;
            lastshotdone_q <= lastshotdone_d;
        end
    end

    assign busy         = busy_q;
    assign trig         = trig_q;
    assign acq_we       = acq_we_q;
    assign acq_addr     = acq_addr_q;
    assign acc_clr      = acc_clr_q;
    assign acqbuf_rst   = acqbuf_rst_q;
    assign shotcnt      = shotcnt_q;
    assign lastshotdone = lastshotdone_q;

endmodule

// File: tb/tb_shot_sequencer.sv
// Testbench for shot_sequencer. Each run builds an expected per-cycle trace
// (offsets from the start strobe) from the shot timing rules, then drives
// the DUT and compares every output each cycle.
module tb_shot_sequencer;

    localparam int unsigned NSHOT_W = 16;
    localparam int unsigned DELAY_W = 16;
    localparam int unsigned DECIM_W = 8;
    localparam int unsigned ADDR_W  = 12;
    localparam int          MAXC    = 256;

    logic               clk;
    logic               reset;
    logic               stb_start;
    logic               stb_abort;
    logic [NSHOT_W-1:0] nshot;
    logic [DELAY_W-1:0] delayaftertrig;
    logic [DECIM_W-1:0] decimator;
    logic [ADDR_W-1:0]  acqlen;
    logic               resetacc;
    logic               rearm;
    logic               busy;
    logic               trig;
    logic               acq_we;
    logic [ADDR_W-1:0]  acq_addr;
    logic               acc_clr;
    logic               acqbuf_rst;
    logic [NSHOT_W-1:0] shotcnt;
    logic               lastshotdone;

    shot_sequencer #(
        .NSHOT_W (NSHOT_W),
        .DELAY_W (DELAY_W),
        .DECIM_W (DECIM_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stb_start      (stb_start),
        .stb_abort      (stb_abort),
        .nshot          (nshot),
        .delayaftertrig (delayaftertrig),
        .decimator      (decimator),
        .acqlen         (acqlen),
        .resetacc       (resetacc),
        .rearm          (rearm),
        .busy           (busy),
        .trig           (trig),
        .acq_we         (acq_we),
        .acq_addr       (acq_addr),
        .acc_clr        (acc_clr),
        .acqbuf_rst     (acqbuf_rst),
        .shotcnt        (shotcnt),
        .lastshotdone   (lastshotdone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Expected trace, indexed by cycle offset from the start strobe
    bit m_trig [MAXC];
    bit m_we   [MAXC];
    bit m_busy [MAXC];
    bit m_lsd  [MAXC];
    bit m_clr  [MAXC];
    bit m_brst [MAXC];
    int m_addr [MAXC];
    int m_cnt  [MAXC];
    int m_done;
    int lo_from;
    int lo_len;

    task automatic chk(input string tag, input int off, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s off=%0d observed=%0d expected=%0d", tag, off, obs, expv);
        end
    endtask

    function automatic bit rearm_at(input int c);
        return !((c >= lo_from) && (c < lo_from + lo_len));
    endfunction

    // Shot k: trigger output at t, writes at t+1+d+j*(dec+1), ARM at
    // t+d+l*(dec+1) where the count is bumped; next trigger two cycles after
    // the first ARM cycle that sees rearm; lastshotdone two cycles after the
    // final ARM cycle.
    task automatic build_model(input int n, input int d, input int dec, input int l,
                               input bit resacc, input int lo);
        int t;
        int a;
        int r;
        for (int c = 0; c < MAXC; c++) begin
            m_trig[c] = 0; m_we[c] = 0; m_busy[c] = 0; m_lsd[c] = 0;
            m_clr[c] = 0; m_brst[c] = 0; m_addr[c] = -1; m_cnt[c] = 0;
        end
        m_brst[1] = 1;
        m_clr[1]  = resacc;
        lo_len    = lo;
        lo_from   = 2 + d + l * (dec + 1);
        m_done    = 2;
        t         = 2;
        for (int k = 0; k < n; k++) begin
            m_trig[t] = 1;
            for (int j = 0; j < l; j++) begin
                m_we[t + 1 + d + j * (dec + 1)]   = 1;
                m_addr[t + 1 + d + j * (dec + 1)] = j;
            end
            a = t + d + l * (dec + 1);
            for (int c = a; c < MAXC; c++) m_cnt[c] = k + 1;
            if (k == n - 1) begin
                m_done = a + 2;
            end else begin
                r = a;
                while (!rearm_at(r)) r++;
                t = r + 2;
            end
        end
        for (int c = 1; c < m_done; c++) m_busy[c] = 1;
        for (int c = m_done; c < MAXC; c++) m_lsd[c] = 1;
    endtask

    // Abort: idle from the next cycle, count frozen, no done flag
    task automatic apply_abort(input int off);
        for (int c = off + 1; c < MAXC; c++) begin
            m_trig[c] = 0; m_we[c] = 0; m_busy[c] = 0; m_lsd[c] = 0;
            m_cnt[c] = m_cnt[off]; m_addr[c] = -1;
        end
        m_done = off + 1;
    endtask

    // abort_off: -1 none, -2 random, else fixed offset; stop_at > 0 ends early
    task automatic run(input int n, input int d, input int dec, input int l,
                       input bit resacc, input int lo, input int abort_off, input int stop_at);
        int last;
        int ab;
        build_model(n, d, dec, l, resacc, lo);
        ab = abort_off;
        if (ab == -2) ab = (m_done > 1) ? int'($urandom_range(m_done - 1, 1)) : -1;
        if (ab > 0) apply_abort(ab);
        last = (stop_at > 0) ? stop_at : m_done + 3;
        nshot          = NSHOT_W'(n);
        delayaftertrig = DELAY_W'(d);
        decimator      = DECIM_W'(dec);
        acqlen         = ADDR_W'(l);
        resetacc       = resacc;
        rearm          = 1'b1;
        stb_abort      = 1'b0;
        stb_start      = 1'b1;
        for (int off = 1; off <= last; off++) begin
            @(posedge clk);
            #1;
            chk("trig",         off, 32'(trig),         32'(m_trig[off]));
            chk("acq_we",       off, 32'(acq_we),       32'(m_we[off]));
            chk("busy",         off, 32'(busy),         32'(m_busy[off]));
            chk("lastshotdone", off, 32'(lastshotdone), 32'(m_lsd[off]));
            chk("acc_clr",      off, 32'(acc_clr),      32'(m_clr[off]));
            chk("acqbuf_rst",   off, 32'(acqbuf_rst),   32'(m_brst[off]));
            chk("shotcnt",      off, 32'(shotcnt),      32'(m_cnt[off]));
            if (m_we[off]) chk("acq_addr", off, 32'(acq_addr), 32'(m_addr[off]));
            // Config churn and stray starts while busy must have no effect
            stb_start      = (off < m_done) && ((off % 5 == 3) || ($urandom_range(3) == 0));
            stb_abort      = (off == ab);
            rearm          = rearm_at(off);
            nshot          = NSHOT_W'($urandom);
            delayaftertrig = DELAY_W'($urandom);
            decimator      = DECIM_W'($urandom);
            acqlen         = ADDR_W'($urandom);
            resetacc       = 1'($urandom);
        end
        stb_start = 1'b0;
        stb_abort = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},       0, 32'(busy),         32'd0);
        chk({tag, "_trig"},       0, 32'(trig),         32'd0);
        chk({tag, "_acq_we"},     0, 32'(acq_we),       32'd0);
        chk({tag, "_acq_addr"},   0, 32'(acq_addr),     32'd0);
        chk({tag, "_acc_clr"},    0, 32'(acc_clr),      32'd0);
        chk({tag, "_acqbuf_rst"}, 0, 32'(acqbuf_rst),   32'd0);
        chk({tag, "_shotcnt"},    0, 32'(shotcnt),      32'd0);
        chk({tag, "_lsd"},        0, 32'(lastshotdone), 32'd0);
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b1;
        stb_start      = 1'b0;
        stb_abort      = 1'b0;
        nshot          = '0;
        delayaftertrig = '0;
        decimator      = '0;
        acqlen         = '0;
        resetacc       = 1'b0;
        rearm          = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        #2 reset = 1'b0;
        @(posedge clk);
        #1;

        // Abort and start together in IDLE: no start
        stb_start = 1'b1;
        stb_abort = 1'b1;
        resetacc  = 1'b1;
        nshot     = NSHOT_W'(2);
        @(posedge clk);
        #1;
        stb_start = 1'b0;
        stb_abort = 1'b0;
        chk("abort_start_busy", 1, 32'(busy),       32'd0);
        chk("abort_start_brst", 1, 32'(acqbuf_rst), 32'd0);
        chk("abort_start_clr",  1, 32'(acc_clr),    32'd0);
        @(posedge clk);
        #1;
        chk("abort_start_trig", 2, 32'(trig), 32'd0);

        // Directed shot sequences
        run(3, 4, 0, 8, 1'b1, 0,  -1, 0);
        run(2, 0, 3, 4, 1'b0, 0,  -1, 0);
        run(0, 3, 1, 4, 1'b1, 0,  -1, 0);
        run(3, 2, 1, 3, 1'b0, 10, -1, 0);
        run(3, 1, 0, 6, 1'b0, 0,  15, 0);
        run(2, 0, 0, 0, 1'b1, 0,  -1, 0);

        // Async reset in the middle of the second shot's delay
        run(2, 8, 0, 2, 1'b0, 0, -1, 18);
        #2 reset = 1'b1;
        #1;
        chk_all_zero("async_reset");
        #2 reset = 1'b0;
        run(2, 1, 1, 3, 1'b1, 0, -1, 0);

        // Randomized sequences
        for (int i = 0; i < 10; i++) begin
            run(int'($urandom_range(3, 0)), int'($urandom_range(6, 0)),
                int'($urandom_range(3, 0)), int'($urandom_range(6, 0)),
                1'($urandom), ($urandom_range(1) == 0) ? 0 : int'($urandom_range(12, 1)),
                ($urandom_range(2) == 0) ? -2 : -1, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
